// File: rtl/hex_line_renderer.sv
// Two-stage VGA overlay that draws NUM_DIGITS hex digits of a frame-latched value with a built-in 8x16 font.
// Optional macro HEX_CURSOR_EN adds a blinking cursor that inverts one selected digit.

module hex_line_renderer #(
   parameter int NUM_DIGITS   = 8,
   parameter int COORD_W      = 10,
   parameter int X0           = 0,
   parameter int Y0           = 0,
   parameter int SCALE_LOG2   = 0,
`ifdef HEX_CURSOR_EN
   parameter int BLINK_FRAMES = 32,
`endif
   localparam int DATA_W      = 4 * NUM_DIGITS,
   localparam int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               pix_valid,
   input  logic               frame_start,
   input  logic [DATA_W-1:0]  data_in,
   input  logic               lz_en,
`ifdef HEX_CURSOR_EN
   input  logic               cursor_en,
   input  logic [DIG_W-1:0]   cursor_pos,
`endif
   output logic               pix_on,
   output logic               in_box,
   output logic               pix_valid_out
);

   localparam int BOX_W = (NUM_DIGITS * 8) << SCALE_LOG2;
   localparam int BOX_H = 16 << SCALE_LOG2;
   localparam logic [COORD_W:0] X_HI = (COORD_W+1)'(X0 + BOX_W);
   localparam logic [COORD_W:0] Y_HI = (COORD_W+1)'(Y0 + BOX_H);

   if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_scale
      $error("hex_line_renderer: SCALE_LOG2 must be in 0..2");
   end
   if (X0 < 0 || Y0 < 0 || (X0 + BOX_W) > (1 << COORD_W) || (Y0 + BOX_H) > (1 << COORD_W)) begin : g_bad_box
      $error("hex_line_renderer: text box does not fit in COORD_W");
   end

   // Glyph rows 2..11 packed MSB-first; rows 0,1,12..15 and the space glyph (16) are blank.
   function automatic logic [7:0] font_row(input logic [4:0] code, input logic [3:0] row);
      logic [79:0] g;
      logic [7:0]  r;
      case (code)
         5'd0:    g = 80'h3E_63_63_67_6F_7B_73_63_63_3E;
         5'd1:    g = 80'h0C_1C_3C_0C_0C_0C_0C_0C_0C_3F;
         5'd2:    g = 80'h3E_63_03_06_0C_18_30_60_63_7F;
         5'd3:    g = 80'h3E_63_03_03_1E_03_03_03_63_3E;
         5'd4:    g = 80'h06_0E_1E_36_66_7F_06_06_06_0F;
         5'd5:    g = 80'h7F_60_60_60_7E_03_03_03_63_3E;
         5'd6:    g = 80'h1C_30_60_60_7E_63_63_63_63_3E;
         5'd7:    g = 80'h7F_63_03_06_0C_18_18_18_18_18;
         5'd8:    g = 80'h3E_63_63_63_3E_63_63_63_63_3E;
         5'd9:    g = 80'h3E_63_63_63_3F_03_03_03_06_3C;
         5'd10:   g = 80'h08_1C_36_63_63_7F_63_63_63_63;
         5'd11:   g = 80'h7E_33_33_33_3E_33_33_33_33_7E;
         5'd12:   g = 80'h1E_33_61_60_60_60_60_61_33_1E;
         5'd13:   g = 80'h7C_36_33_33_33_33_33_33_36_7C;
         5'd14:   g = 80'h7F_33_31_34_3C_34_30_31_33_7F;
         5'd15:   g = 80'h7F_33_31_34_3C_34_30_30_30_78;
         default: g = '0;
      endcase
      case (row)
         4'd2:    r = g[79:72];
         4'd3:    r = g[71:64];
         4'd4:    r = g[63:56];
         4'd5:    r = g[55:48];
         4'd6:    r = g[47:40];
         4'd7:    r = g[39:32];
         4'd8:    r = g[31:24];
         4'd9:    r = g[23:16];
         4'd10:   r = g[15:8];
         4'd11:   r = g[7:0];
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [DATA_W-1:0] data_shadow_q, data_shadow_d;
   logic [DIG_W-1:0]  digit_q, digit_d;
   logic [2:0]        dh_q, dh_d;
   logic [3:0]        dv_q, dv_d;
   logic              box_q, box_d;
   logic              valid_q, valid_d;
   logic              pix_on_q, pix_on_d;
   logic              in_box_q, in_box_d;
   logic              pix_valid_out_q, pix_valid_out_d;

   logic              x_lo_ok, y_lo_ok;
   logic [COORD_W-1:0] rx, ry;

   // Lower bound compare is elided when the edge sits at coordinate 0.
   if (X0 > 0) begin : g_xlo
      assign x_lo_ok = ({1'b0, pix_x} >= (COORD_W+1)'(X0));
   end else begin : g_xlo_zero
      assign x_lo_ok = 1'b1;
   end
   if (Y0 > 0) begin : g_ylo
      assign y_lo_ok = ({1'b0, pix_y} >= (COORD_W+1)'(Y0));
   end else begin : g_ylo_zero
      assign y_lo_ok = 1'b1;
   end

   always_comb begin
      box_d         = x_lo_ok && y_lo_ok && ({1'b0, pix_x} < X_HI) && ({1'b0, pix_y} < Y_HI);
      rx            = pix_x - COORD_W'(X0);
      ry            = pix_y - COORD_W'(Y0);
      digit_d       = DIG_W'(rx >> (3 + SCALE_LOG2));
      dh_d          = 3'(rx >> SCALE_LOG2);
      dv_d          = 4'(ry >> SCALE_LOG2);
      valid_d       = pix_valid;
      data_shadow_d = frame_start ? data_in : data_shadow_q;
   end

   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] lead_zero;
   logic [3:0]            nibble;
   logic                  suppress;
   logic [4:0]            glyph;
   logic [7:0]            row_bits;
   logic                  font_bit;
   logic                  invert;

`ifdef HEX_CURSOR_EN
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
   logic            phase_q, phase_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (frame_start) begin
         if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign invert = cursor_en & phase_q & (digit_q == cursor_pos);
`else
   assign invert = 1'b0;
`endif

   // lead_zero[d] is set when digit d and every digit to its left are zero.
   always_comb begin
      lead_zero = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib[i] = data_shadow_q[DATA_W-1-4*i -: 4];
      end
      lead_zero[0] = (nib[0] == 4'd0);
      for (int i = 1; i < NUM_DIGITS; i++) begin
         lead_zero[i] = lead_zero[i-1] & (nib[i] == 4'd0);
      end
      nibble          = nib[digit_q];
      suppress        = lz_en && (digit_q != DIG_W'(NUM_DIGITS - 1)) && lead_zero[digit_q];
      glyph           = suppress ? 5'd16 : {1'b0, nibble};
      row_bits        = font_row(glyph, dv_q);
      font_bit        = row_bits[~dh_q];
      in_box_d        = box_q & valid_q;
      pix_on_d        = in_box_d & (font_bit ^ invert);
      pix_valid_out_d = valid_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_shadow_q   <= '0;
         digit_q         <= '0;
         dh_q            <= '0;
         dv_q            <= '0;
         box_q           <= 1'b0;
         valid_q         <= 1'b0;
         pix_on_q        <= 1'b0;
         in_box_q        <= 1'b0;
         pix_valid_out_q <= 1'b0;
      end else begin
         data_shadow_q   <= data_shadow_d;
         digit_q         <= digit_d;
         dh_q            <= dh_d;
         dv_q            <= dv_d;
         box_q           <= box_d;
         valid_q         <= valid_d;
         pix_on_q        <= pix_on_d;
         in_box_q        <= in_box_d;
         pix_valid_out_q <= pix_valid_out_d;
      end
   end

   assign pix_on        = pix_on_q;
   assign in_box        = in_box_q;
   assign pix_valid_out = pix_valid_out_q;

endmodule

// File: tb/tb_hex_line_renderer.sv
// Bench for hex_line_renderer: three parameterisations driven in parallel, checked against a pixel-level model.
// Cursor checks are compiled in only when HEX_CURSOR_EN is defined.

module tb_hex_line_renderer;

   localparam int N_DUT = 3;
   localparam int P_X0 [N_DUT] = '{0, 0, 100};
   localparam int P_Y0 [N_DUT] = '{0, 0, 20};
   localparam int P_S  [N_DUT] = '{0, 1, 0};
   localparam int BLINK = 2;

   // Glyph rows 2..11; every other row is blank.
   localparam logic [7:0] FONT [16][10] = '{
      '{8'h3E,8'h63,8'h63,8'h67,8'h6F,8'h7B,8'h73,8'h63,8'h63,8'h3E},
      '{8'h0C,8'h1C,8'h3C,8'h0C,8'h0C,8'h0C,8'h0C,8'h0C,8'h0C,8'h3F},
      '{8'h3E,8'h63,8'h03,8'h06,8'h0C,8'h18,8'h30,8'h60,8'h63,8'h7F},
      '{8'h3E,8'h63,8'h03,8'h03,8'h1E,8'h03,8'h03,8'h03,8'h63,8'h3E},
      '{8'h06,8'h0E,8'h1E,8'h36,8'h66,8'h7F,8'h06,8'h06,8'h06,8'h0F},
      '{8'h7F,8'h60,8'h60,8'h60,8'h7E,8'h03,8'h03,8'h03,8'h63,8'h3E},
      '{8'h1C,8'h30,8'h60,8'h60,8'h7E,8'h63,8'h63,8'h63,8'h63,8'h3E},
      '{8'h7F,8'h63,8'h03,8'h06,8'h0C,8'h18,8'h18,8'h18,8'h18,8'h18},
      '{8'h3E,8'h63,8'h63,8'h63,8'h3E,8'h63,8'h63,8'h63,8'h63,8'h3E},
      '{8'h3E,8'h63,8'h63,8'h63,8'h3F,8'h03,8'h03,8'h03,8'h06,8'h3C},
      '{8'h08,8'h1C,8'h36,8'h63,8'h63,8'h7F,8'h63,8'h63,8'h63,8'h63},
      '{8'h7E,8'h33,8'h33,8'h33,8'h3E,8'h33,8'h33,8'h33,8'h33,8'h7E},
      '{8'h1E,8'h33,8'h61,8'h60,8'h60,8'h60,8'h60,8'h61,8'h33,8'h1E},
      '{8'h7C,8'h36,8'h33,8'h33,8'h33,8'h33,8'h33,8'h33,8'h36,8'h7C},
      '{8'h7F,8'h33,8'h31,8'h34,8'h3C,8'h34,8'h30,8'h31,8'h33,8'h7F},
      '{8'h7F,8'h33,8'h31,8'h34,8'h3C,8'h34,8'h30,8'h30,8'h30,8'h78}
   };

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pix_x, pix_y;
   logic        pix_valid, frame_start, lz_en;
   logic [31:0] data_in;
`ifdef HEX_CURSOR_EN
   logic        cursor_en;
   logic [2:0]  cursor_pos;
`endif
   logic        pix_on_o [N_DUT];
   logic        in_box_o [N_DUT];
   logic        pv_o     [N_DUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      hex_line_renderer #(
         .NUM_DIGITS(8), .COORD_W(10), .X0(P_X0[g]), .Y0(P_Y0[g]), .SCALE_LOG2(P_S[g])
`ifdef HEX_CURSOR_EN
         , .BLINK_FRAMES(BLINK)
`endif
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
         .pix_valid(pix_valid), .frame_start(frame_start), .data_in(data_in), .lz_en(lz_en),
`ifdef HEX_CURSOR_EN
         .cursor_en(cursor_en), .cursor_pos(cursor_pos),
`endif
         .pix_on(pix_on_o[g]), .in_box(in_box_o[g]), .pix_valid_out(pv_o[g])
      );
   end

   int          checks = 0;
   int          failures = 0;
   int          on_cnt0 = 0;
   logic [31:0] sh_m = '0;
   int          fcnt_m = 0;
   bit          phase_m = 0;
   int          p1_x = 0, p1_y = 0;
   bit          p1_v = 0;
   bit          cen_g = 0;
   int          cpos_g = 0;

   typedef struct {
      int          inst;
      int          x;
      int          y;
      logic [31:0] data;
      bit          lz;
      bit          on;
      bit          box;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model(input int inst, input int x, input int y, input bit v,
                                 input logic [31:0] d, input bit lz, input bit cur_on,
                                 input int cur_pos, output bit on, output bit box);
      int          sc, col, row, dg, nb;
      logic [31:0] upper;
      bit          px;
      sc  = 1 << P_S[inst];
      box = v && x >= P_X0[inst] && x < P_X0[inst] + 64 * sc &&
                 y >= P_Y0[inst] && y < P_Y0[inst] + 16 * sc;
      on  = 0;
      if (box) begin
         col   = (x - P_X0[inst]) / sc;
         row   = (y - P_Y0[inst]) / sc;
         dg    = col / 8;
         upper = d >> (4 * (7 - dg));
         nb    = int'(upper & 32'hF);
         px    = 0;
         if (!(lz && dg < 7 && upper == 0) && row >= 2 && row <= 11)
            px = FONT[nb][row-2][7 - (col % 8)];
         if (cur_on && dg == cur_pos) px = !px;
         on = px;
      end
   endfunction

   // One clock: present a pixel, predict the output of the pixel presented one cycle earlier.
   task automatic step(input int x, input int y, input bit v, input bit fs,
                       input logic [31:0] d, input bit lz);
      bit eo [N_DUT];
      bit eb [N_DUT];
      bit epv;
      pix_x       = 10'(x);
      pix_y       = 10'(y);
      pix_valid   = v;
      frame_start = fs;
      data_in     = d;
      lz_en       = lz;
`ifdef HEX_CURSOR_EN
      cursor_en   = cen_g;
      cursor_pos  = 3'(cpos_g);
`endif
      for (int i = 0; i < N_DUT; i++)
         model(i, p1_x, p1_y, p1_v, sh_m, lz, cen_g && phase_m, cpos_g, eo[i], eb[i]);
      epv = p1_v;
      if (fs) begin
         sh_m = d;
         if (fcnt_m == BLINK - 1) begin
            fcnt_m  = 0;
            phase_m = !phase_m;
         end else begin
            fcnt_m++;
         end
      end
      p1_x = x;
      p1_y = y;
      p1_v = v;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         chk($sformatf("pix_on[%0d]", i), int'(pix_on_o[i]), int'(eo[i]));
         chk($sformatf("in_box[%0d]", i), int'(in_box_o[i]), int'(eb[i]));
         chk($sformatf("pix_valid_out[%0d]", i), int'(pv_o[i]), int'(epv));
      end
      if (pix_on_o[0]) on_cnt0++;
   endtask

   task automatic frame(input logic [31:0] d, input bit lz);
      step(0, 0, 0, 1, d, lz);
      step(0, 0, 0, 0, d, lz);
      step(0, 0, 0, 0, d, lz);
   endtask

   task automatic scan(input int y, input int xl, input int xh, input logic [31:0] d, input bit lz);
      for (int x = xl; x <= xh; x++) step(x, y, 1, 0, d, lz);
      step(0, 0, 0, 0, d, lz);
      step(0, 0, 0, 0, d, lz);
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < N_DUT; i++) begin
         chk($sformatf("%s_pix_on[%0d]", tag, i), int'(pix_on_o[i]), 0);
         chk($sformatf("%s_in_box[%0d]", tag, i), int'(in_box_o[i]), 0);
         chk($sformatf("%s_pv[%0d]", tag, i), int'(pv_o[i]), 0);
      end
   endtask

   // Asynchronous reset asserted mid-cycle; returns just after an edge with rst_n released.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk_zero("rst_async");
      sh_m    = '0;
      fcnt_m  = 0;
      phase_m = 0;
      p1_v    = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
      rst_n = 1'b1;
   endtask

   function automatic void add_vec(input int inst, input int x, input int y, input logic [31:0] d,
                                   input bit lz, input bit on, input bit box);
      vec_t v;
      v.inst = inst; v.x = x; v.y = y; v.data = d; v.lz = lz; v.on = on; v.box = box;
      vecs.push_back(v);
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      bit          lz_r;

      rst_n = 1'b0; pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_start = 1'b0;
      data_in = '0; lz_en = 1'b0;
`ifdef HEX_CURSOR_EN
      cursor_en = 1'b0; cursor_pos = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      add_vec(0,   4,  2, 32'h1234ABCD, 0, 1, 1);
      add_vec(0,   3,  2, 32'h1234ABCD, 0, 0, 1);
      add_vec(0,   5,  2, 32'h1234ABCD, 0, 1, 1);
      add_vec(0,   6,  2, 32'h1234ABCD, 0, 0, 1);
      add_vec(0,   2,  2, 32'h00000000, 0, 1, 1);
      add_vec(0,   1,  2, 32'h00000000, 0, 0, 1);
      add_vec(0,   4,  2, 32'hA0000000, 0, 1, 1);
      add_vec(0,   3,  2, 32'hA0000000, 0, 0, 1);
      add_vec(0,  57, 11, 32'h0000000F, 1, 1, 1);
      add_vec(0,  61, 11, 32'h0000000F, 1, 0, 1);
      add_vec(0,  56, 11, 32'h0000000F, 1, 0, 1);
      add_vec(0,   2, 11, 32'h0000000F, 1, 0, 1);
      add_vec(0,   2,  2, 32'h00000000, 1, 0, 1);
      add_vec(0,  58,  2, 32'h00000000, 1, 1, 1);
      add_vec(0,   2, 11, 32'h10000000, 0, 1, 1);
      add_vec(0,   1, 11, 32'h10000000, 0, 0, 1);
      add_vec(0,   4, 16, 32'h1234ABCD, 0, 0, 0);
      add_vec(0,  64,  2, 32'h1234ABCD, 0, 0, 0);
      add_vec(1,   8,  4, 32'h1234ABCD, 0, 1, 1);
      add_vec(1,  11,  5, 32'h1234ABCD, 0, 1, 1);
      add_vec(1,   7,  4, 32'h1234ABCD, 0, 0, 1);
      add_vec(1, 127, 31, 32'h1234ABCD, 0, 0, 1);
      add_vec(1, 128,  0, 32'h1234ABCD, 0, 0, 0);
      add_vec(1,   0, 32, 32'h1234ABCD, 0, 0, 0);
      add_vec(2,  99, 22, 32'h1234ABCD, 0, 0, 0);
      add_vec(2, 164, 22, 32'h1234ABCD, 0, 0, 0);
      add_vec(2, 100, 22, 32'h1234ABCD, 0, 0, 1);
      add_vec(2, 104, 22, 32'h1234ABCD, 0, 1, 1);
      add_vec(2, 163, 22, 32'h1234ABCD, 0, 0, 1);
      add_vec(2, 104, 19, 32'h1234ABCD, 0, 0, 0);
      add_vec(2, 104, 35, 32'h1234ABCD, 0, 0, 1);
      add_vec(2, 104, 36, 32'h1234ABCD, 0, 0, 0);

      // Reset in the middle of a lit stream, then two-cycle restart latency.
      frame(32'h1234ABCD, 0);
      repeat (4) step(4, 2, 1, 0, 32'h1234ABCD, 0);
      do_reset();
      step(4, 2, 1, 1, 32'h1234ABCD, 0);
      chk("restart_pv_cycle1", int'(pv_o[0]), 0);
      step(5, 2, 1, 0, 32'h1234ABCD, 0);
      chk("restart_pv_cycle2", int'(pv_o[0]), 1);
      chk("restart_on_cycle2", int'(pix_on_o[0]), 1);
      step(3, 2, 1, 0, 32'h1234ABCD, 0);
      chk("restart_on_cycle3", int'(pix_on_o[0]), 1);
      step(0, 0, 0, 0, 32'h1234ABCD, 0);
      chk("restart_on_cycle4", int'(pix_on_o[0]), 0);

      foreach (vecs[k]) begin
         step(0, 0, 0, 1, vecs[k].data, vecs[k].lz);
         step(vecs[k].x, vecs[k].y, 1, 0, vecs[k].data, vecs[k].lz);
         step(0, 0, 0, 0, vecs[k].data, vecs[k].lz);
         chk($sformatf("vec%0d_on", k), int'(pix_on_o[vecs[k].inst]), int'(vecs[k].on));
         chk($sformatf("vec%0d_box", k), int'(in_box_o[vecs[k].inst]), int'(vecs[k].box));
      end

      // Mid-frame data change stays invisible until the next frame_start.
      frame(32'h1234ABCD, 0);
      on_cnt0 = 0;
      scan(2, 0, 63, 32'hFFFFFFFF, 0);
      chk("midframe_row2_count", on_cnt0, 30);
      frame(32'hFFFFFFFF, 0);
      on_cnt0 = 0;
      scan(2, 0, 63, 32'hFFFFFFFF, 0);
      chk("newframe_row2_count", on_cnt0, 56);

      // Value zero with suppression lights only the last digit.
      frame(32'h0, 1);
      on_cnt0 = 0;
      scan(2, 0, 55, 32'h0, 1);
      chk("lz_zero_left_count", on_cnt0, 0);
      on_cnt0 = 0;
      scan(2, 56, 63, 32'h0, 1);
      chk("lz_zero_last_count", on_cnt0, 5);

`ifdef HEX_CURSOR_EN
      do_reset();
      cen_g  = 1;
      cpos_g = 3;
      for (int f = 1; f <= 4; f++) begin
         frame(32'h1234ABCD, 0);
         on_cnt0 = 0;
         scan(2, 24, 31, 32'h1234ABCD, 0);
         chk($sformatf("cursor_frame%0d_count", f), on_cnt0, (f == 2 || f == 3) ? 6 : 2);
      end
`endif

      lz_r = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 127) == 0) lz_r = !lz_r;
`ifdef HEX_CURSOR_EN
         if ($urandom_range(0, 255) == 0) cen_g = !cen_g;
         if ($urandom_range(0, 255) == 0) cpos_g = int'($urandom_range(0, 7));
`endif
         d = $urandom >> (4 * $urandom_range(0, 8));
         step(int'($urandom_range(0, 199)), int'($urandom_range(0, 39)),
              $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0, d, lz_r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
